// File: rtl/uart_rx_frame.sv
// uart_rx_frame: LSB-first asynchronous frame receiver with a valid/ready holding register.
// Optional parity stage is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_frame #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       Bus_Clk_i,
  input  logic       RST_i,
  input  logic       Rx_Enable_i,
  input  logic       Rx_i,
  input  logic       Baud_rate_re_i,
  output logic       Clear_br_cnt_o,
  input  logic       Parity_Odd_i,
  output logic [7:0] Rx_Data_o,
  output logic       Rx_Valid_o,
  input  logic       Rx_Ready_i,
  output logic       Frame_Err_o,
  output logic       Parity_Err_o,
  output logic       Overrun_o
);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_dly_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [2:0]             cnt_q;
  logic [7:0]             data_q;
  logic                   valid_q;
  logic                   ferr_q;
  logic                   perr_q;
  logic                   ovr_q;
  logic                   clr_q;
  logic                   rx_s;
  logic                   fall;
  logic                   last_bit;
  logic                   perr_d;

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign fall     = rx_dly_q & ~rx_s;
  assign last_bit = (cnt_q == 3'(DATA_BITS - 1));

`ifdef UART_RX_PARITY_EN
  logic par_err_q;
  assign perr_d = par_err_q;
`else
  // Odd/even select has no meaning without a parity bit; the flag stays 0.
  assign perr_d = Parity_Odd_i & 1'b0;
`endif

  always_ff @(posedge Bus_Clk_i) begin
    if (RST_i) begin
      state_q  <= S_IDLE;
      sync_q   <= '1;
      rx_dly_q <= 1'b1;
      shift_q  <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      perr_q   <= 1'b0;
      ovr_q    <= 1'b0;
      clr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], Rx_i};
      rx_dly_q <= rx_s;
      clr_q    <= 1'b0;
      ovr_q    <= 1'b0;

      // Consume first; a completion in the same cycle re-asserts valid below.
      if (valid_q && Rx_Ready_i) valid_q <= 1'b0;

      if (!Rx_Enable_i) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (fall) begin
              clr_q   <= 1'b1;
              state_q <= S_START;
            end
          end
          S_START: begin
            if (Baud_rate_re_i) begin
              if (!rx_s) begin
                state_q <= S_DATA;
                cnt_q   <= '0;
              end else begin
                state_q <= S_IDLE;
              end
            end
          end
          S_DATA: begin
            if (Baud_rate_re_i) begin
              shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
              cnt_q   <= cnt_q + 3'd1;
              if (last_bit) begin
`ifdef UART_RX_PARITY_EN
                state_q <= S_PARITY;
`else
                state_q <= S_STOP;
`endif
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          S_PARITY: begin
            if (Baud_rate_re_i) begin
              par_err_q <= (^shift_q) ^ rx_s ^ Parity_Odd_i;
              state_q   <= S_STOP;
            end
          end
`endif
          S_STOP: begin
            // Leave mid-stop-bit so a back-to-back start edge is not missed.
            if (Baud_rate_re_i) begin
              state_q <= S_IDLE;
              if (!valid_q || Rx_Ready_i) begin
                data_q  <= 8'(shift_q);
                ferr_q  <= ~rx_s;
                perr_q  <= perr_d;
                valid_q <= 1'b1;
              end else begin
                ovr_q <= 1'b1;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign Clear_br_cnt_o = clr_q;
  assign Rx_Data_o      = data_q;
  assign Rx_Valid_o     = valid_q;
  assign Frame_Err_o    = ferr_q;
  assign Parity_Err_o   = perr_q;
  assign Overrun_o      = ovr_q;

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Serial-receive stage for the FCB UART path. Consumes the mid-bit sample strobe from `baud_generator` and drives that block's counter-clear input so the bit timing re-aligns on every start edge. Deserialises LSB-first asynchronous frames: start, `DATA_BITS` data bits, optional parity, one stop bit. Presents each byte on a valid/ready holding register with frame, parity and overrun status.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal range 5–8.
- `SYNC_STAGES`, default 2: flops in the `Rx_i` synchroniser; minimum 2.
- `Bus_Clk_i`  in  1: single clock; all logic on its rising edge.
- `RST_i`  in  1: reset, synchronous and active-high.
- `Rx_Enable_i`  in  1: receiver enable; low forces IDLE.
- `Rx_i`  in  1: asynchronous serial line, idle high.
- `Baud_rate_re_i`  in  1: one-cycle mid-bit sample strobe from `baud_generator`.
- `Clear_br_cnt_o`  out  1: one-cycle pulse to `baud_generator` `smc_clear_br_cnt`; zeroes its bit counter.
- `Parity_Odd_i`  in  1: 1 selects odd parity, 0 selects even. Used only when parity is compiled in.
- `Rx_Data_o`  out  8: received byte; bits above `DATA_BITS-1` read 0.
- `Rx_Valid_o`  out  1: holding register full.
- `Rx_Ready_i`  in  1: consumer accepts; a transfer occurs when valid and ready are both high.
- `Frame_Err_o`  out  1: stop bit sampled 0; qualified by `Rx_Valid_o`.
- `Parity_Err_o`  out  1: parity mismatch; qualified by `Rx_Valid_o`.
- `Overrun_o`  out  1: one-cycle pulse when a completed frame is dropped.

## Operation
- **Synchroniser.** `SYNC_STAGES` flops, all reset to 1; the last stage is `rx_s`. Falling-edge detect compares `rx_s` with a one-cycle delayed copy.
- **FSM states:** IDLE, START, DATA, PARITY (only when compiled in), STOP.
- **IDLE.** On a falling edge of `rx_s` with `Rx_Enable_i` high:
  - pulse `Clear_br_cnt_o` for one cycle;
  - go to START.
- **START.** On `Baud_rate_re_i`:
  - `rx_s`==0: go to DATA and clear the bit counter;
  - `rx_s`==1 (glitch): go to IDLE; nothing is delivered and no error is flagged.
- **DATA.** On each `Baud_rate_re_i`, shift `rx_s` into the MSB of the shift register and increment the 3-bit counter. After the strobe that samples bit `DATA_BITS-1`, go to PARITY (if present) or STOP.
- **PARITY.** On strobe, compute the parity error:
  - even (`Parity_Odd_i`=0): error = XOR(data, parity bit);
  - odd (`Parity_Odd_i`=1): error = the inverse of that XOR.
  - Then go to STOP.
- **STOP.** On strobe, set frame error = ~`rx_s`, complete the frame, and go to IDLE in the same cycle. Leaving mid-stop-bit lets a back-to-back start edge be detected.
- **Right-justification.** The shift register is justified so the first received bit lands at `Rx_Data_o[0]`.
- **Frame completion:**
  - `Rx_Valid_o`==0, or `Rx_Ready_i`==1 in the same cycle: load data and both error flags; `Rx_Valid_o` is 1 next cycle.
  - `Rx_Valid_o`==1 and `Rx_Ready_i`==0: the new frame is discarded, the held byte is unchanged, and `Overrun_o` pulses.
- **Consume.** `Rx_Valid_o` & `Rx_Ready_i` with no completion in that cycle: `Rx_Valid_o` clears next cycle. Data and flags hold their last values.
- **Frame error.** A frame-error byte is still delivered.
- **Break (line held low).** After STOP the FSM returns to IDLE. No new frame starts until the line returns high and then falls again.
- **Enable low.**
  - `Rx_Enable_i`=0 in any state: FSM goes to IDLE next cycle and any partial frame is dropped silently.
  - The holding register and `Rx_Valid_o` are unaffected.
  - `Clear_br_cnt_o` is never asserted while enable is low.

## Timing
- **Reset values (all synchronous, applied at the clock edge with `RST_i`=1):**
  - FSM: IDLE;
  - synchroniser: all 1;
  - `Rx_Data_o`=0, `Rx_Valid_o`=0, `Frame_Err_o`=0, `Parity_Err_o`=0, `Overrun_o`=0, `Clear_br_cnt_o`=0.
- **Reset mid-frame** abandons the frame identically.
- **Clear pulse timing.** `Clear_br_cnt_o` rises the cycle after the falling edge appears on `rx_s`; it is registered.
- **Input latency.** `Rx_i` to `rx_s`: `SYNC_STAGES` cycles.
- **Output latency.** `Rx_Valid_o` rises one cycle after the `Baud_rate_re_i` that samples the stop bit.
- **Strobe usage.** `Baud_rate_re_i` is used only in START, DATA, PARITY and STOP; it is ignored in IDLE.
- **Outputs.** All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- **Macro:** `UART_RX_PARITY_EN`.
- **Defined:**
  - the PARITY state exists;
  - frame = start + `DATA_BITS` + parity + stop;
  - `Parity_Err_o` is live.
- **Undefined:**
  - no PARITY state or parity logic;
  - frame = start + `DATA_BITS` + stop;
  - `Parity_Err_o` is tied 0;
  - `Parity_Odd_i` is ignored.
- Port list is identical in both builds.

## Test plan
Bench setup for all scenarios: `Rx_i` is driven with an 8-cycle bit period. The block is coupled to `baud_generator` with `Divisor_i`=4 (8-cycle bit), `SYNC_STAGES`=2, `DATA_BITS`=8.
- **Single frame.** Frame 0xA5, even parity, stop=1, `Rx_Ready_i` held 1 → `Rx_Data_o`=0xA5 and `Rx_Valid_o`=1 for one cycle; both errors 0; `Clear_br_cnt_o` pulses exactly once, one cycle after the falling edge appears on `rx_s`.
- **Start glitch.** 3-cycle low pulse on `Rx_i` → FSM returns to IDLE; `Rx_Valid_o` stays 0; no error flags.
- **Frame error.** Frame 0x3C with stop bit 0 → `Rx_Data_o`=0x3C, `Frame_Err_o`=1. Line then held low for 40 cycles → no further frame until the line rises and falls again.
- **Overrun.** Back-to-back frames 0x11 then 0x22 with `Rx_Ready_i`=0 → `Rx_Data_o` stays 0x11 and `Overrun_o` pulses once. Then `Rx_Ready_i`=1 for one cycle → `Rx_Valid_o`=0 next cycle.
- **Parity error (`UART_RX_PARITY_EN` defined).** `Parity_Odd_i`=1, frame 0x01 with parity bit 1 → `Parity_Err_o`=1. Same frame with parity bit 0 → `Parity_Err_o`=0.
- **Disable and reset mid-frame.** `Rx_Enable_i` dropped after 3 data bits → nothing delivered and no clear pulse while low. Separately, `RST_i` pulsed for 1 cycle mid-frame → all outputs at reset values on the next cycle.
